zbus_cycle_capture: RTL and testbench

// Downstream consumer of the Z80 bus strobes that the top level receives from the CPU (or the T80 in sim).

---
 rtl/zbus_cycle_capture_pkg.sv | 42 ++++
 rtl/zbus_cycle_capture_if.sv | 25 ++
 rtl/zbus_rec_fifo.sv | 47 ++++
 rtl/zbus_cycle_capture.sv | 135 +++++++++++++
 tb/tb_zbus_cycle_capture.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/zbus_cycle_capture_pkg.sv
// Shared types for the Z80 bus-cycle capture block: record codes, record
// payload, synchronised bus sample and FSM state encoding.
package zbus_cycle_capture_pkg;

  localparam int unsigned REC_W = 28;

  typedef enum logic [2:0] {
    REC_OPFETCH = 3'd0,
    REC_MEMRD   = 3'd1,
    REC_MEMWR   = 3'd2,
    REC_IORD    = 3'd3,
    REC_IOWR    = 3'd4,
    REC_INTACK  = 3'd5
  } rec_type_e;

  typedef struct packed {
    rec_type_e   typ;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rom;
  } rec_t;

  // One sample of every asynchronous bus input, carried down the sync line as a unit.
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rom;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
  } bus_smp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/zbus_cycle_capture_if.sv
// Z80 bus strobes/address/data in, captured-record valid/ready stream out.
// slave : the capture block (consumes the Z80 bus, produces records)
// master: the environment (drives the Z80 bus, consumes records)
interface zbus_cycle_capture_if;
  logic [15:0] a;
  logic [7:0]  d;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic        romnram;
  logic        rec_valid;
  logic        rec_ready;
  logic [2:0]  rec_type;
  logic [15:0] rec_addr;
  logic [7:0]  rec_data;
  logic        rec_rom;

  modport slave (
    input  a, d, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, romnram, rec_ready,
    output rec_valid, rec_type, rec_addr, rec_data, rec_rom
  );

  modport master (
    output a, d, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, romnram, rec_ready,
    input  rec_valid, rec_type, rec_addr, rec_data, rec_rom
  );
endinterface

// File: rtl/zbus_rec_fifo.sv
// Synchronous show-ahead record FIFO, depth 2**FIFO_LOG2.
// Ports: clk, rst_n (sync, active-low), push_i/din_i write side,
// pop_i/dout_o read side (dout_o is the head), full_o, empty_o.
// A push while full is accepted only if a pop happens in the same cycle.
module zbus_rec_fifo
  import zbus_cycle_capture_pkg::*;
#(
  parameter int unsigned FIFO_LOG2 = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rec_t din_i,
  input  logic pop_i,
  output rec_t dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned DEPTH = 2 ** FIFO_LOG2;
  localparam int unsigned PW    = FIFO_LOG2 + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = rec_t'(mem_q[rd_ptr_q[FIFO_LOG2-1:0]]);

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= din_i;
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
endmodule

// File: rtl/zbus_cycle_capture.sv
// Synchronises Z80 bus strobes into fclk, classifies each completed bus
// cycle and queues one {type,addr,data,rom} record per cycle.
// Ports: fclk, rst_n (sync, active-low); bus (slave modport: Z80 inputs,
// record valid/ready stream); overflow (sticky drop flag); drop_cnt
// (saturating count of records dropped on a full FIFO).
module zbus_cycle_capture
  import zbus_cycle_capture_pkg::*;
#(
  parameter int unsigned FIFO_LOG2   = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  fclk,
  input  logic                  rst_n,
  zbus_cycle_capture_if.slave   bus,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);
  bus_smp_t  pin_w;
  bus_smp_t  sync_q [SYNC_STAGES];
  bus_smp_t  s;
  state_e    state_q;
  logic      arm_q;
  rec_t      cur_q;
  logic      start_hit;
  rec_type_e start_type;
  logic      cyc_ok;
  logic      push, pop, full, empty, drop;
  rec_t      head;
  logic      overflow_q;
  logic [7:0] drop_cnt_q;

  assign pin_w = '{a: bus.a, d: bus.d, rom: bus.romnram, mreq_n: bus.mreq_n,
                   iorq_n: bus.iorq_n, rd_n: bus.rd_n, wr_n: bus.wr_n,
                   m1_n: bus.m1_n, rfsh_n: bus.rfsh_n};

  // Strobes and data share one delay line so they stay aligned. Left unreset
  // so a cycle in flight across reset stays visible to the arming logic.
  always_ff @(posedge fclk) begin
    sync_q[0] <= pin_w;
    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Start qualifiers in priority order; refresh (!rfsh&!mreq) matches none.
  always_comb begin
    start_hit  = 1'b1;
    start_type = REC_OPFETCH;
    if (!s.m1_n && !s.mreq_n && !s.rd_n)                    start_type = REC_OPFETCH;
    else if (!s.m1_n && !s.iorq_n)                          start_type = REC_INTACK;
    else if (s.m1_n && !s.mreq_n && !s.rd_n && s.rfsh_n)    start_type = REC_MEMRD;
    else if (!s.mreq_n && !s.wr_n && s.rfsh_n)              start_type = REC_MEMWR;
    else if (s.m1_n && !s.iorq_n && !s.rd_n)                start_type = REC_IORD;
    else if (s.m1_n && !s.iorq_n && !s.wr_n)                start_type = REC_IOWR;
    else                                                    start_hit  = 1'b0;
  end

  // The latched cycle stays open while its own strobe and its mreq/iorq are low.
  always_comb begin
    cyc_ok = 1'b0;
    case (cur_q.typ)
      REC_OPFETCH, REC_MEMRD: cyc_ok = !s.rd_n && !s.mreq_n;
      REC_MEMWR:              cyc_ok = !s.wr_n && !s.mreq_n;
      REC_IORD:               cyc_ok = !s.rd_n && !s.iorq_n;
      REC_IOWR:               cyc_ok = !s.wr_n && !s.iorq_n;
      REC_INTACK:             cyc_ok = !s.iorq_n;
      default:                cyc_ok = 1'b0;
    endcase
  end

  // Cycle FSM. arm_q blocks starts until the bus has been idle once after reset.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
      cur_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!arm_q) begin
            if (!start_hit) arm_q <= 1'b1;
          end else if (start_hit) begin
            state_q <= ST_ACTIVE;
            cur_q   <= '{typ: start_type, addr: s.a, data: s.d, rom: s.rom};
          end
        end
        ST_ACTIVE: begin
          if (cyc_ok) begin
            cur_q.addr <= s.a;
            cur_q.data <= s.d;
            cur_q.rom  <= s.rom;
          end else begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign push = (state_q == ST_COMMIT);
  assign pop  = bus.rec_valid && bus.rec_ready;
  assign drop = push && full && !pop;

  zbus_rec_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clk     (fclk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (cur_q),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Drop accounting: sticky flag and saturating counter.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.rec_valid = !empty;
  assign bus.rec_type  = head.typ;
  assign bus.rec_addr  = head.addr;
  assign bus.rec_data  = head.data;
  assign bus.rec_rom   = head.rom;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_zbus_cycle_capture.sv
// Directed bench for zbus_cycle_capture: drives Z80-style bus cycles,
// keeps a queue of the records each cycle must produce, and checks every
// record the DUT hands over against that queue, plus literal head checks.
module tb_zbus_cycle_capture;
  localparam int DEPTH = 8;
  localparam int MAX_LAT = 4;   // SYNC_STAGES + 2

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       overflow;
  logic [7:0] drop_cnt;

  zbus_cycle_capture_if bus();

  zbus_cycle_capture #(.FIFO_LOG2(3), .SYNC_STAGES(2)) dut (
    .fclk     (fclk),
    .rst_n    (rst_n),
    .bus      (bus),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 fclk = ~fclk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [27:0] exp_q [$];
  int model_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fclk);
      #2;
    end
  endtask

  task automatic release_bus();
    bus.mreq_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
    bus.wr_n   = 1'b1; bus.m1_n   = 1'b1; bus.rfsh_n = 1'b1;
  endtask

  // Model: each issued cycle yields one record; a full FIFO with no consumer drops it.
  task automatic model_push(input int kind, input logic [15:0] addr, input logic [7:0] data, input logic rom);
    if (exp_q.size() >= DEPTH && !bus.rec_ready) model_drops++;
    else exp_q.push_back({3'(kind), addr, data, rom});
  endtask

  // Every record handed over must be the oldest expected one.
  always @(negedge fclk) begin
    if (rst_n && bus.rec_valid && bus.rec_ready) begin
      if (exp_q.size() == 0)
        chk("pop_unexpected", 32'({bus.rec_type, bus.rec_addr, bus.rec_data, bus.rec_rom}), 32'hFFFF_FFFF);
      else
        chk("pop_record", 32'({bus.rec_type, bus.rec_addr, bus.rec_data, bus.rec_rom}), 32'(exp_q.pop_front()));
    end
  end

  // kind: 0 OPFETCH 1 MEMRD 2 MEMWR 3 IORD 4 IOWR 5 INTACK. Data switches to
  // d_late halfway through the strobe and to garbage once the strobe releases.
  task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] d_early,
                           input logic [7:0] d_late, input logic rom, input int n_low,
                           input bit expect_rec, output int lat);
    bus.a = addr; bus.d = d_early; bus.romnram = rom;
    case (kind)
      0: begin bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
      1: begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
      2: begin bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
      3: begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
      4: begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
      default: begin bus.m1_n = 1'b0; bus.iorq_n = 1'b0; end
    endcase
    if (expect_rec) model_push(kind, addr, d_late, rom);
    for (int i = 0; i < n_low; i++) begin
      if (i >= n_low / 2) bus.d = d_late;
      tick(1);
    end
    release_bus();
    bus.d = 8'h5C; bus.a = 16'hDEAD; bus.romnram = ~rom;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge fclk);
      if (bus.rec_valid && lat < 0) lat = k;
    end
    tick(1);
  endtask

  // Literal head check, then a one-cycle pop and an empty check.
  task automatic check_head(input string name, input int kind, input logic [15:0] addr,
                            input logic [7:0] data, input logic rom);
    @(negedge fclk);
    chk({name, "_valid"}, 32'(bus.rec_valid), 32'd1);
    chk({name, "_type"},  32'(bus.rec_type),  32'(kind));
    chk({name, "_addr"},  32'(bus.rec_addr),  32'(addr));
    chk({name, "_data"},  32'(bus.rec_data),  32'(data));
    chk({name, "_rom"},   32'(bus.rec_rom),   32'(rom));
    tick(1);
    bus.rec_ready = 1'b1;
    tick(1);
    bus.rec_ready = 1'b0;
    @(negedge fclk);
    chk({name, "_empty_after_pop"}, 32'(bus.rec_valid), 32'd0);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    release_bus();
    bus.a = '0; bus.d = '0; bus.romnram = 1'b0; bus.rec_ready = 1'b0;
    rst_n = 1'b0;
    tick(5);
    @(negedge fclk);
    chk("rst_valid", 32'(bus.rec_valid), 32'd0);
    chk("rst_type",  32'(bus.rec_type),  32'd0);
    chk("rst_addr",  32'(bus.rec_addr),  32'd0);
    chk("rst_data",  32'(bus.rec_data),  32'd0);
    chk("rst_rom",   32'(bus.rec_rom),   32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);
    chk("rst_drop",  32'(drop_cnt),      32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(4);

    // 1: opcode fetch; the late data value must win
    bus_cycle(0, 16'h0000, 8'h00, 8'hF3, 1'b1, 4, 1'b1, lat);
    chk("t1_latency_ok", 32'(lat >= 1 && lat <= MAX_LAT), 32'd1);
    check_head("t1", 0, 16'h0000, 8'hF3, 1'b1);

    // 2: memory write
    bus_cycle(2, 16'h5B00, 8'hAA, 8'hAA, 1'b0, 3, 1'b1, lat);
    chk("t2_latency_ok", 32'(lat >= 1 && lat <= MAX_LAT), 32'd1);
    check_head("t2", 2, 16'h5B00, 8'hAA, 1'b0);

    // 3: IO write, then a refresh that must not produce a record
    bus_cycle(4, 16'h7FFD, 8'h10, 8'h10, 1'b1, 3, 1'b1, lat);
    check_head("t3", 4, 16'h7FFD, 8'h10, 1'b1);
    bus.a = 16'h007F; bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0;
    tick(3);
    release_bus();
    tick(8);
    @(negedge fclk);
    chk("t3_refresh_norec", 32'(bus.rec_valid), 32'd0);
    tick(1);

    // 4: interrupt acknowledge preceded by M1 alone
    bus.a = 16'h0038; bus.m1_n = 1'b0;
    tick(2);
    bus_cycle(5, 16'h0038, 8'hFF, 8'hFF, 1'b0, 3, 1'b1, lat);
    check_head("t4", 5, 16'h0038, 8'hFF, 1'b0);

    // 5: nine reads into an eight-deep FIFO with no consumer
    for (int i = 0; i < 9; i++)
      bus_cycle(1, 16'(i), 8'h30 + 8'(i), 8'h30 + 8'(i), 1'b0, 3, 1'b1, lat);
    @(negedge fclk);
    chk("t5_model_drops", 32'(model_drops), 32'd1);
    chk("t5_drop_cnt",    32'(drop_cnt),    32'd1);
    chk("t5_overflow",    32'(overflow),    32'd1);
    chk("t5_valid",       32'(bus.rec_valid), 32'd1);
    chk("t5_head_addr",   32'(bus.rec_addr),  32'h0000);
    tick(1);
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 30 && bus.rec_valid; i++) tick(1);
    bus.rec_ready = 1'b0;
    @(negedge fclk);
    chk("t5_drained_valid", 32'(bus.rec_valid), 32'd0);
    chk("t5_drained_model", 32'(exp_q.size()),  32'd0);
    tick(1);

    // 6: reset pulse inside a read whose strobe is still low after release
    bus.a = 16'h1234; bus.d = 8'h77; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_drops = 0;
    tick(3);
    release_bus();
    tick(8);
    @(negedge fclk);
    chk("t6_no_rec",   32'(bus.rec_valid), 32'd0);
    chk("t6_ovf_clr",  32'(overflow),      32'd0);
    chk("t6_drop_clr", 32'(drop_cnt),      32'd0);
    tick(1);
    bus_cycle(1, 16'h4321, 8'h11, 8'h5A, 1'b1, 4, 1'b1, lat);
    chk("t6_latency_ok", 32'(lat >= 1 && lat <= MAX_LAT), 32'd1);
    check_head("t6", 1, 16'h4321, 8'h5A, 1'b1);

    chk("end_model_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
